// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode with register file, N-source operand
// forwarding, early beq/bne resolution, load-use / branch-dependency stall
// and a valid/ready ID/EX pipeline register.
// Optional feature macro: ID_STAGE_WRITE_BYPASS_EN (same-cycle writeback
// data returned on a register-file read of the index being written).
module id_stage_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_FWD        = 3
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               InValid,
    output logic                               InReady,
    input  logic [31:0]                        Instruction,
    input  logic [DATA_WIDTH-1:0]              PCResult,
    input  logic                               RegWriteIn,
    input  logic [REG_ADDR_WIDTH-1:0]          WriteRegister,
    input  logic [DATA_WIDTH-1:0]              WriteData,
    input  logic [NUM_FWD-1:0]                 FwdValid,
    input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0]  FwdReg,
    input  logic [NUM_FWD*DATA_WIDTH-1:0]      FwdData,
    input  logic                               Flush,
    input  logic                               OutReady,
    output logic                               OutValid,
    output logic [DATA_WIDTH-1:0]              OutReadData1,
    output logic [DATA_WIDTH-1:0]              OutReadData2,
    output logic [DATA_WIDTH-1:0]              OutImm,
    output logic [REG_ADDR_WIDTH-1:0]          OutDest,
    output logic                               OutRegWrite,
    output logic                               OutMemRead,
    output logic [31:0]                        OutInstruction,
    output logic                               BranchTaken,
    output logic [DATA_WIDTH-1:0]              BranchTarget
);

    localparam int NUM_REGS = 2**REG_ADDR_WIDTH;

    // Instruction fields
    logic [5:0]                opcode;
    logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
    assign opcode = Instruction[31:26];
    assign rs     = REG_ADDR_WIDTH'(Instruction[25:21]);
    assign rt     = REG_ADDR_WIDTH'(Instruction[20:16]);
    assign rd     = REG_ADDR_WIDTH'(Instruction[15:11]);

    // Register file state
    logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];

    // ID/EX pipeline register state
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     out_rd1_q, out_rd1_d;
    logic [DATA_WIDTH-1:0]     out_rd2_q, out_rd2_d;
    logic [DATA_WIDTH-1:0]     out_imm_q, out_imm_d;
    logic [REG_ADDR_WIDTH-1:0] out_dest_q, out_dest_d;
    logic                      out_rw_q, out_rw_d;
    logic                      out_mr_q, out_mr_d;
    logic [31:0]               out_instr_q, out_instr_d;

    // Decode / operand results
    logic [DATA_WIDTH-1:0]     op_a, op_b;
    logic [DATA_WIDTH-1:0]     imm_sext, imm_ext;
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic                      dec_rw, dec_mr;
    logic                      is_branch, br_cond, hazard, in_ready, xfer;

    // Register file next state: entry 0 is never written
    always_comb begin
        rf_d = rf_q;
        if (RegWriteIn && WriteRegister != '0)
            rf_d[WriteRegister] = WriteData;
    end

    // Register file storage, cleared on reset
    always_ff @(posedge Clk) begin
        if (Reset)
            rf_q <= '{default: '0};
        else
            rf_q <= rf_d;
    end

    // Operand select: index 0 -> 0, else youngest matching forward source,
    // else (optionally) same-cycle writeback, else register file
    always_comb begin
        op_a = rf_q[rs];
        op_b = rf_q[rt];
`ifdef ID_STAGE_WRITE_BYPASS_EN
        if (RegWriteIn && WriteRegister == rs) op_a = WriteData;
        if (RegWriteIn && WriteRegister == rt) op_b = WriteData;
`endif
        // Walk oldest to youngest so the lowest index wins
        for (int i = NUM_FWD-1; i >= 0; i--) begin
            if (FwdValid[i] && FwdReg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs)
                op_a = FwdData[i*DATA_WIDTH +: DATA_WIDTH];
            if (FwdValid[i] && FwdReg[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rt)
                op_b = FwdData[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (rs == '0) op_a = '0;
        if (rt == '0) op_b = '0;
    end

    // Control decode and immediate extension
    always_comb begin
        dec_rw = 1'b0;
        dec_mr = 1'b0;
        dest   = '0;
        if (opcode == 6'h00) begin
            dest   = rd;
            dec_rw = 1'b1;
        end else if (opcode inside {[6'h08:6'h0F]}) begin
            dest   = rt;
            dec_rw = 1'b1;
        end else if (opcode == 6'h20 || opcode == 6'h23) begin
            dest   = rt;
            dec_rw = 1'b1;
            dec_mr = 1'b1;
        end else if (opcode == 6'h03) begin
            dest   = REG_ADDR_WIDTH'(31);
            dec_rw = 1'b1;
        end
        if (!dec_rw) dest = '0;

        imm_sext = {{(DATA_WIDTH-16){Instruction[15]}}, Instruction[15:0]};
        imm_ext  = imm_sext;
        if (opcode inside {[6'h0C:6'h0E]})
            imm_ext = {{(DATA_WIDTH-16){1'b0}}, Instruction[15:0]};
    end

    // Hazard detection, handshake and early branch resolution
    always_comb begin
        is_branch = (opcode == 6'h04) || (opcode == 6'h05);
        br_cond   = (opcode == 6'h04) ? (op_a == op_b) : (op_a != op_b);
        // A branch needs its operands now, so any in-flight ALU result stalls it
        hazard    = out_valid_q && (out_dest_q != '0) &&
                    ((out_dest_q == rs) || (out_dest_q == rt)) &&
                    (out_mr_q || (is_branch && out_rw_q));
        in_ready  = !Flush && !hazard && (OutReady || !out_valid_q);
        xfer      = InValid && in_ready;
    end

    assign InReady      = in_ready;
    assign BranchTaken  = xfer && is_branch && br_cond;
    assign BranchTarget = PCResult + (imm_sext << 2);

    // ID/EX next state: flush drops valid but keeps payload; a stalled
    // downstream holds everything
    always_comb begin
        out_valid_d = out_valid_q;
        out_rd1_d   = out_rd1_q;
        out_rd2_d   = out_rd2_q;
        out_imm_d   = out_imm_q;
        out_dest_d  = out_dest_q;
        out_rw_d    = out_rw_q;
        out_mr_d    = out_mr_q;
        out_instr_d = out_instr_q;
        if (Flush) begin
            out_valid_d = 1'b0;
        end else if (OutReady || !out_valid_q) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_rd1_d   = op_a;
                out_rd2_d   = op_b;
                out_imm_d   = imm_ext;
                out_dest_d  = dest;
                out_rw_d    = dec_rw;
                out_mr_d    = dec_mr;
                out_instr_d = Instruction;
            end
        end
    end

    // ID/EX register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_rd1_q   <= '0;
            out_rd2_q   <= '0;
            out_imm_q   <= '0;
            out_dest_q  <= '0;
            out_rw_q    <= 1'b0;
            out_mr_q    <= 1'b0;
            out_instr_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rd1_q   <= out_rd1_d;
            out_rd2_q   <= out_rd2_d;
            out_imm_q   <= out_imm_d;
            out_dest_q  <= out_dest_d;
            out_rw_q    <= out_rw_d;
            out_mr_q    <= out_mr_d;
            out_instr_q <= out_instr_d;
        end
    end

    assign OutValid       = out_valid_q;
    assign OutReadData1   = out_rd1_q;
    assign OutReadData2   = out_rd2_q;
    assign OutImm         = out_imm_q;
    assign OutDest        = out_dest_q;
    assign OutRegWrite    = out_rw_q;
    assign OutMemRead     = out_mr_q;
    assign OutInstruction = out_instr_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed table-driven bench for id_stage_pipe plus hand sequences for
// same-cycle writeback and reset during a stall.
module tb_id_stage_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] Instruction;
    logic [31:0] PCResult;
    logic        RegWriteIn;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [2:0]  FwdValid;
    logic [14:0] FwdReg;
    logic [95:0] FwdData;
    logic        Flush;
    logic        OutReady;
    logic        OutValid;
    logic [31:0] OutReadData1, OutReadData2, OutImm;
    logic [4:0]  OutDest;
    logic        OutRegWrite, OutMemRead;
    logic [31:0] OutInstruction;
    logic        BranchTaken;
    logic [31:0] BranchTarget;

    id_stage_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_FWD(3)) dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Instruction(Instruction), .PCResult(PCResult),
        .RegWriteIn(RegWriteIn), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .FwdValid(FwdValid), .FwdReg(FwdReg), .FwdData(FwdData),
        .Flush(Flush), .OutReady(OutReady), .OutValid(OutValid),
        .OutReadData1(OutReadData1), .OutReadData2(OutReadData2), .OutImm(OutImm),
        .OutDest(OutDest), .OutRegWrite(OutRegWrite), .OutMemRead(OutMemRead),
        .OutInstruction(OutInstruction), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0]      instr, pc;
        logic             in_valid, out_ready, flush;
        logic [2:0]       fv;
        logic [2:0][4:0]  fr;
        logic [2:0][31:0] fd;
        logic             wb_en;
        logic [4:0]       wb_reg;
        logic [31:0]      wb_data;
        // expected: combinational, before the edge
        logic             e_rdy, e_bt, chk_tgt;
        logic [31:0]      e_tgt;
        // expected: registered, after the edge
        logic             e_ov, chk_pay;
        logic [31:0]      e_instr, e_imm, e_rd1, e_rd2;
        logic [4:0]       e_dest;
        logic             e_rw, e_mr;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc);
        vec_t v;
        v = '{default: '0};
        v.instr = instr; v.pc = pc; v.e_instr = instr;
        v.in_valid = 1'b1; v.out_ready = 1'b1;
        v.e_rdy = 1'b1; v.e_ov = 1'b1; v.chk_pay = 1'b1;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Instruction   = v.instr;
        PCResult      = v.pc;
        InValid       = v.in_valid;
        OutReady      = v.out_ready;
        Flush         = v.flush;
        FwdValid      = v.fv;
        FwdReg        = v.fr;
        FwdData       = v.fd;
        RegWriteIn    = v.wb_en;
        WriteRegister = v.wb_reg;
        WriteData     = v.wb_data;
    endtask

    task automatic idle();
        InValid = 1'b0; Instruction = '0; PCResult = '0; Flush = 1'b0;
        OutReady = 1'b1; FwdValid = '0; FwdReg = '0; FwdData = '0;
        RegWriteIn = 1'b0; WriteRegister = '0; WriteData = '0;
    endtask

    initial begin
        vec_t v, lw_v, add10_v, sw_v, addi14_v;
        logic [31:0] exp_byp;

        // ---- stimulus table ----
        // 0: addi $1,$0,5 ; writeback $9=0x1234 same cycle
        v = mk(32'h20010005, 32'h4); v.wb_en = 1; v.wb_reg = 9; v.wb_data = 32'h1234;
        v.e_dest = 1; v.e_imm = 5; v.e_rw = 1; vq.push_back(v);
        // 1: lw $2,0($0)
        v = mk(32'h8C020000, 32'h8); v.e_dest = 2; v.e_rw = 1; v.e_mr = 1; vq.push_back(v);
        lw_v = v;
        // 2: add $3,$2,$2 -> load-use stall, bubble, lw payload held
        v = lw_v; v.instr = 32'h00421820; v.pc = 32'hC; v.e_rdy = 0; v.e_ov = 0; vq.push_back(v);
        // 3: add accepted
        v = mk(32'h00421820, 32'hC); v.e_dest = 3; v.e_imm = 32'h1820; v.e_rw = 1; vq.push_back(v);
        // 4: beq $4,$5,+3 with both operands 7 via forwarding
        v = mk(32'h10850003, 32'h100); v.fv = 3'b011;
        v.fr[0] = 4; v.fd[0] = 7; v.fr[1] = 5; v.fd[1] = 7;
        v.e_bt = 1; v.chk_tgt = 1; v.e_tgt = 32'h10C;
        v.e_imm = 3; v.e_rd1 = 7; v.e_rd2 = 7; vq.push_back(v);
        // 5: same beq, $5=8 -> not taken
        v.fd[1] = 8; v.e_bt = 0; v.e_rd2 = 8; vq.push_back(v);
        // 6: add $10,$6,$9: two valid sources on $6, invalid third ignored
        v = mk(32'h00C95020, 32'h104); v.fv = 3'b011;
        v.fr[0] = 6; v.fd[0] = 32'hA; v.fr[1] = 6; v.fd[1] = 32'hB; v.fr[2] = 6; v.fd[2] = 32'hC;
        v.e_dest = 10; v.e_rw = 1; v.e_imm = 32'h5020; v.e_rd1 = 32'hA; v.e_rd2 = 32'h1234;
        vq.push_back(v);
        add10_v = v;
        // 7: bne $10,$0,+1 right after producer -> branch-dependency stall
        v = add10_v; v.instr = 32'h15400001; v.pc = 32'h200;
        v.fv = 3'b100; v.fr = '0; v.fd = '0; v.fr[2] = 10; v.fd[2] = 1;
        v.e_rdy = 0; v.e_bt = 0; v.chk_tgt = 1; v.e_tgt = 32'h204; v.e_ov = 0; vq.push_back(v);
        // 8: bne resolves taken using forward source 2
        v = mk(32'h15400001, 32'h200); v.fv = 3'b100; v.fr[2] = 10; v.fd[2] = 1;
        v.e_bt = 1; v.chk_tgt = 1; v.e_tgt = 32'h204; v.e_imm = 1; v.e_rd1 = 1; vq.push_back(v);
        // 9: ori $11,$0,0x8000 -> zero-extended
        v = mk(32'h340B8000, 32'h204); v.e_dest = 11; v.e_rw = 1; v.e_imm = 32'h00008000; vq.push_back(v);
        // 10: addi $12,$0,-4 -> sign-extended
        v = mk(32'h200CFFFC, 32'h208); v.e_dest = 12; v.e_rw = 1; v.e_imm = 32'hFFFFFFFC; vq.push_back(v);
        // 11: jal -> dest 31
        v = mk(32'h0C000010, 32'h20C); v.e_dest = 31; v.e_rw = 1; v.e_imm = 32'h10; vq.push_back(v);
        // 12: sw -> no writeback, dest forced 0
        v = mk(32'hAC000000, 32'h210); vq.push_back(v);
        sw_v = v;
        // 13-15: OutReady low three cycles, Flush in the second
        v = sw_v; v.instr = 32'h200E0007; v.pc = 32'h214; v.out_ready = 0; v.e_rdy = 0; vq.push_back(v);
        v.flush = 1; v.e_ov = 0; vq.push_back(v);
        v = mk(32'h200E0007, 32'h214); v.out_ready = 0; v.e_dest = 14; v.e_rw = 1; v.e_imm = 7;
        vq.push_back(v);
        addi14_v = v;
        // 16: nothing valid, downstream drains -> payload held, valid drops
        v = addi14_v; v.in_valid = 0; v.out_ready = 1; v.e_ov = 0; vq.push_back(v);

        // ---- reset ----
        idle();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("rst OutValid", OutValid, 0);
        chk("rst OutDest", OutDest, 0);
        chk("rst OutImm", OutImm, 0);
        chk("rst OutReadData1", OutReadData1, 0);
        chk("rst OutRegWrite", OutRegWrite, 0);
        chk("rst OutInstruction", OutInstruction, 0);
        chk("rst BranchTaken", BranchTaken, 0);
        chk("rst InReady", InReady, 1);

        // ---- table ----
        for (int k = 0; k < vq.size(); k++) begin
            @(negedge Clk);
            drive(vq[k]);
            #1;
            chk($sformatf("v%0d InReady", k), InReady, vq[k].e_rdy);
            chk($sformatf("v%0d BranchTaken", k), BranchTaken, vq[k].e_bt);
            if (vq[k].chk_tgt)
                chk($sformatf("v%0d BranchTarget", k), BranchTarget, vq[k].e_tgt);
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d OutValid", k), OutValid, vq[k].e_ov);
            if (vq[k].chk_pay) begin
                chk($sformatf("v%0d OutDest", k), OutDest, vq[k].e_dest);
                chk($sformatf("v%0d OutImm", k), OutImm, vq[k].e_imm);
                chk($sformatf("v%0d OutReadData1", k), OutReadData1, vq[k].e_rd1);
                chk($sformatf("v%0d OutReadData2", k), OutReadData2, vq[k].e_rd2);
                chk($sformatf("v%0d OutRegWrite", k), OutRegWrite, vq[k].e_rw);
                chk($sformatf("v%0d OutMemRead", k), OutMemRead, vq[k].e_mr);
                chk($sformatf("v%0d OutInstruction", k), OutInstruction, vq[k].e_instr);
            end
        end

        // ---- same-cycle writeback vs read of $7 ----
`ifdef ID_STAGE_WRITE_BYPASS_EN
        exp_byp = 32'h55;
`else
        exp_byp = 32'h11;
`endif
        @(negedge Clk);
        idle();
        RegWriteIn = 1; WriteRegister = 7; WriteData = 32'h11;
        @(negedge Clk);
        idle();
        InValid = 1; Instruction = 32'h00E06820;  // add $13,$7,$0
        RegWriteIn = 1; WriteRegister = 7; WriteData = 32'h55;
        @(posedge Clk);
        #1;
        chk("byp OutReadData1", OutReadData1, exp_byp);
        chk("byp OutDest", OutDest, 13);
        @(negedge Clk);
        RegWriteIn = 0;
        @(posedge Clk);
        #1;
        chk("byp after OutReadData1", OutReadData1, 32'h55);

        // ---- reset asserted during a load-use stall ----
        @(negedge Clk);
        idle();
        InValid = 1; Instruction = 32'h8C020000;  // lw $2
        @(negedge Clk);
        Instruction = 32'h00421820;               // add $3,$2,$2
        #1;
        chk("rstall InReady", InReady, 0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        chk("rstall OutValid", OutValid, 0);
        chk("rstall OutDest", OutDest, 0);
        chk("rstall InReady", InReady, 1);

        @(negedge Clk);
        idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
